div_unit: RTL and testbench

Iterative RV32M divide/remainder unit for femtoRV32. It computes DIV, DIVU, REM and REMU on the two register operands, one quotient bit per cycle, and presents a 32-bit result. The result drives one data input of the execute-stage 8-to-1 result-select multiplexer. The control unit stalls the pipeline while `busy` is high and captures `result` when `done` pulses.

---
 rtl/div_unit.sv | 103 ++++++++++
 tb/tb_div_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: iterative RV32M DIV/DIVU/REM/REMU, one restoring quotient bit per cycle
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic        qneg_q, qneg_d, rneg_q, rneg_d;
    logic [31:0] dvd_q, dvd_d, dvs_q, dvs_d, result_q, result_d;
    logic [32:0] rem_q, rem_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        sgn, s1, s2, accept, ovf;
    logic [33:0] diff;
    logic [31:0] quo, rmd;
    // next-state: accept/special cases, one restoring step in RUN, sign fix-up in FIX
    always_comb begin
        sgn      = ~op[0];
        s1       = sgn & rs1[31];
        s2       = sgn & rs2[31];
        accept   = start && (state_q == IDLE || state_q == DONE);
        ovf      = sgn && rs1 == 32'h8000_0000 && rs2 == 32'hFFFF_FFFF;
        diff     = {rem_q, dvd_q[31]} - {2'b0, dvs_q};
        quo      = qneg_q ? -dvd_q : dvd_q;
        rmd      = rneg_q ? -rem_q[31:0] : rem_q[31:0];
        state_d  = state_q;
        op_d     = op_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (accept) begin
            op_d   = op;
            qneg_d = s1 ^ s2;
            rneg_d = s1;
            dvd_d  = s1 ? -rs1 : rs1;
            dvs_d  = s2 ? -rs2 : rs2;
            rem_d  = '0;
            cnt_d  = '0;
            if (rs2 == '0) begin
                result_d = op[1] ? rs1 : 32'hFFFF_FFFF;
                state_d  = DONE;
            end else if (ovf) begin
                result_d = op[1] ? 32'h0 : 32'h8000_0000;
                state_d  = DONE;
            end else begin
                state_d  = RUN;
            end
        end else begin
            case (state_q)
                RUN: begin
                    rem_d   = diff[33] ? {rem_q[31:0], dvd_q[31]} : diff[32:0];
                    dvd_d   = {dvd_q[30:0], ~diff[33]};
                    cnt_d   = cnt_q + 6'd1;
                    state_d = (cnt_q == 6'd31) ? FIX : RUN;
                end
                FIX: begin
                    result_d = op_q[1] ? rmd : quo;
                    state_d  = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end
    // state registers, cleared asynchronously so an aborted operation leaves no trace
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end
    assign busy   = (state_q == RUN) || (state_q == FIX);
    assign done   = (state_q == DONE);
    assign result = result_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: vector table, corner sequences and randomized checks of div_unit
module tb_div_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic        busy, done;
    logic [31:0] result;
    int tests = 0, fails = 0;

    div_unit dut (.clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
                  .busy(busy), .done(done), .result(result));

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'h0) return o[1] ? a : 32'hFFFF_FFFF;
        sa = o[0] ? longint'({32'h0, a}) : longint'($signed(a));
        sb = o[0] ? longint'({32'h0, b}) : longint'($signed(b));
        q = sa / sb;
        r = sa % sb;
        return o[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'h0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
        return 34;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; rs1 = a; rs2 = b;
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); rs1 = $urandom; rs2 = $urandom;
    endtask

    task automatic wait_done(input int init, output logic [31:0] r, output int lat, output int bc);
        lat = init; bc = 0;
        while (!done && lat < 40) begin
            if (busy) bc++;
            @(negedge clk);
            lat++;
        end
        chk("done_seen", {31'b0, done}, 32'd1);
        r = result;
    endtask

    task automatic run_check(input string name, input logic [1:0] o, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp, input int elat);
        logic [31:0] r;
        int lat, bc;
        @(negedge clk);
        issue(o, a, b);
        wait_done(1, r, lat, bc);
        chk({name, "_result"}, r, exp);
        chk({name, "_latency"}, lat, elat);
        chk({name, "_busy_cycles"}, bc, (elat == 1) ? 0 : 33);
        @(negedge clk);
        chk({name, "_done_pulse"}, {31'b0, done}, 32'd0);
        chk({name, "_hold"}, result, exp);
    endtask

    vec_t vt[16];

    initial begin
        logic [31:0] r, a, b;
        logic [1:0]  o;
        int lat, bc;
        bit dseen;
        vt[0]  = '{2'd1, 32'd100,        32'd7,          32'd14,         34};
        vt[1]  = '{2'd3, 32'd100,        32'd7,          32'd2,          34};
        vt[2]  = '{2'd0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34};
        vt[3]  = '{2'd2, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34};
        vt[4]  = '{2'd2, 32'd7,          32'hFFFF_FFFE,  32'd1,          34};
        vt[5]  = '{2'd1, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
        vt[6]  = '{2'd3, 32'd5,          32'd0,          32'd5,          1};
        vt[7]  = '{2'd0, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
        vt[8]  = '{2'd2, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1};
        vt[9]  = '{2'd0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
        vt[10] = '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
        vt[11] = '{2'd1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34};
        vt[12] = '{2'd3, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  34};
        vt[13] = '{2'd0, 32'h8000_0000,  32'd1,          32'h8000_0000,  34};
        vt[14] = '{2'd1, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34};
        vt[15] = '{2'd0, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         34};

        repeat (3) @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        rst = 1'b1;

        foreach (vt[i]) run_check($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].lat);

        @(negedge clk);
        issue(2'd1, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'd0; rs1 = 32'd1000; rs2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(6, r, lat, bc);
        chk("busy_start_result", r, 32'd14);
        chk("busy_start_latency", lat, 34);

        issue(2'd3, 32'd100, 32'd7);
        wait_done(1, r, lat, bc);
        chk("b2b_result", r, 32'd2);
        chk("b2b_latency", lat, 34);
        chk("b2b_busy_cycles", bc, 33);

        @(negedge clk);
        issue(2'd1, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        dseen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) dseen = 1'b1;
        end
        chk("midrst_no_done", {31'b0, dseen}, 32'd0);
        run_check("post_rst", 2'd1, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 34);

        for (int i = 0; i < 60; i++) begin
            o = 2'($urandom);
            a = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: b = -32'($urandom_range(1, 15));
                4: b = a + 32'($urandom_range(0, 2)) - 32'd1;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_check($sformatf("rnd%0d", i), o, a, b, model(o, a, b), model_lat(o, a, b));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
